led_pwm_latch: RTL and testbench
================================

LED_PWM_LATCH -- requirements
Module: led_pwm_latch

Interface
REQ-001 SHALL have parameter WIDTH, default 8: serial frame length in bits and PWM resolution (2^WIDTH-cycle period).
REQ-002 SHALL have port clk  input  1  single clock, shared with the upstream serial shift stage; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  frame enable, active low; the same signal gating the upstream shifter; one bit shifted per clk while low.
REQ-005 SHALL have port shift_data  input  WIDTH  parallel word from the upstream shifter.
REQ-006 SHALL have port duty  output  WIDTH  currently applied duty value.
REQ-007 SHALL have port led_out  output  1  registered PWM drive to the LED.
REQ-008 SHALL have port frame_ok  output  1  one-cycle pulse: valid frame accepted.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: frame ended with bit count != WIDTH.

Function
REQ-010 SHALL register en each cycle as en_q; frame end is the cycle where en==1 and en_q==0.
REQ-011 SHALL keep bit_cnt, wide enough to hold WIDTH+1, incrementing on each clk with en==0 and saturating at WIDTH+1.
REQ-012 SHALL clear bit_cnt to 0 on every clk with en==1.
REQ-013 At frame end with bit_cnt==WIDTH, SHALL load shift_data into pending, set pending_valid, and pulse frame_ok for exactly one cycle, on the following clk edge.
REQ-014 At frame end with bit_cnt!=WIDTH (short or long), SHALL pulse frame_err for one cycle and leave pending and pending_valid unchanged.
REQ-015 frame_ok and frame_err SHALL never be high in the same cycle.
REQ-016 A second valid frame before the PWM boundary SHALL overwrite pending; latest frame wins, with no error.
REQ-017 SHALL keep free-running pwm_cnt, WIDTH bits, incrementing every clk and wrapping from 2^WIDTH-1 to 0.
REQ-018 On the cycle pwm_cnt==2^WIDTH-1 with pending_valid==1, SHALL load duty<=pending and clear pending_valid, so duty changes only at period boundaries (glitch-free).
REQ-019 If a frame end and the boundary coincide, duty SHALL take the pre-edge pending value, pending SHALL take the new word, and pending_valid SHALL end at 1 (set beats clear).
REQ-020 SHALL register led_out <= (pwm_cnt < duty) every cycle, giving one clk of latency and a high time of duty cycles per period.
REQ-021 duty==0 SHALL give led_out constantly 0; duty==2^WIDTH-1 SHALL give led_out low for exactly 1 cycle per period.

Reset
REQ-022 While reset is high, SHALL force duty=0, led_out=0, frame_ok=0, frame_err=0, pending=0, pending_valid=0, bit_cnt=0, pwm_cnt=0 and en_q=1, asynchronously.
REQ-023 A reset during a frame SHALL abort it with no pulse; if en is still low after release, counting restarts from 0, and that partial frame ends in frame_err.
REQ-024 After reset release, the first clk edge SHALL behave as a normal cycle (pwm_cnt becomes 1).

Verification
REQ-025 Bench SHALL cover: en low 8 clks with shift_data=8'h40, then en high -> frame_ok pulses 1 cycle; duty=8'h40 at the next wrap; led_out high 64 of every 256 cycles.
REQ-026 Bench SHALL cover: en low 5 clks, then high -> frame_err 1 cycle, frame_ok 0, duty unchanged.
REQ-027 Bench SHALL cover: en low 12 clks -> frame_err; then a valid frame with 8'hFF -> led_out low exactly 1 cycle per period.
REQ-028 Bench SHALL cover: two valid frames 8'h10 then 8'h80 within one period -> duty goes 0 to 8'h80 directly at the boundary; 8'h10 is never applied.
REQ-029 Bench SHALL cover: frame end on the same edge as pwm_cnt==255 with pending 8'h20 already valid and new word 8'h30 -> duty=8'h20 now, 8'h30 at the next boundary.
REQ-030 Bench SHALL cover: reset asserted mid-frame after 4 bits -> all outputs 0 immediately; with en held low 3 more clks then high -> frame_err, duty stays 0.

Source files
------------

// File: rtl/led_pwm_latch.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_latch
// Description : Latches a serially shifted duty word on frame end and drives
//               a glitch-free PWM LED output, updating duty at period wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_latch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] shift_data,
    output logic [WIDTH-1:0] duty,
    output logic             led_out,
    output logic             frame_ok,
    output logic             frame_err
);

    localparam int               CNT_W       = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] c_BITS_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_BITS_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_PWM_LAST  = '1;

    logic             r_en_q;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_pending;
    logic             r_pending_valid;
    logic [WIDTH-1:0] r_pwm_cnt;
    logic [WIDTH-1:0] r_duty;
    logic             r_led;
    logic             r_frame_ok;
    logic             r_frame_err;

    logic             w_frame_end;
    logic             w_frame_good;
    logic             w_frame_bad;
    logic             w_boundary;

    assign w_frame_end  = en & ~r_en_q;
    assign w_frame_good = w_frame_end & (r_bit_cnt == c_BITS_FULL);
    assign w_frame_bad  = w_frame_end & (r_bit_cnt != c_BITS_FULL);
    assign w_boundary   = (r_pwm_cnt == c_PWM_LAST) & r_pending_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_q <= 1'b1;
        end else begin
            r_en_q <= en;
        end
    end

    // Saturate one past WIDTH so an over-long frame can never alias to WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
        end else if (en) begin
            r_bit_cnt <= '0;
        end else if (r_bit_cnt != c_BITS_SAT) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_ok  <= w_frame_good;
            r_frame_err <= w_frame_bad;
        end
    end

    // A new word arriving on the boundary edge keeps pending_valid set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_frame_good) begin
            r_pending       <= shift_data;
            r_pending_valid <= 1'b1;
        end else if (w_boundary) begin
            r_pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_led     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_boundary) begin
                r_duty <= r_pending;
            end
            r_led <= (r_pwm_cnt < r_duty);
        end
    end

    assign duty      = r_duty;
    assign led_out   = r_led;
    assign frame_ok  = r_frame_ok;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_latch
// Description : Randomised and directed bench for led_pwm_latch against a
//               cycle-level behavioural model of the frame/PWM rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] shift_data;
    logic [7:0] duty;
    logic       led_out;
    logic       frame_ok;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: low-cycle count of the open frame, elapsed
    // cycles since reset (PWM phase is that modulo 256), and latched words.
    int         m_low;
    bit         m_prev_en;
    logic [7:0] m_pending;
    bit         m_pvalid;
    logic [7:0] m_duty;
    int         m_t;
    logic       m_ok;
    logic       m_err;
    logic       m_led;

    led_pwm_latch #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .shift_data (shift_data),
        .duty       (duty),
        .led_out    (led_out),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_low     = 0;
        m_prev_en = 1'b1;
        m_pending = 8'h00;
        m_pvalid  = 1'b0;
        m_duty    = 8'h00;
        m_t       = 0;
        m_ok      = 1'b0;
        m_err     = 1'b0;
        m_led     = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] d);
        int phase;
        bit fend;
        phase = m_t % 256;
        m_led = (phase < int'(m_duty));
        fend  = e && !m_prev_en;
        m_ok  = fend && (m_low == 8);
        m_err = fend && (m_low != 8);
        if (phase == 255 && m_pvalid) begin
            m_duty   = m_pending;
            m_pvalid = 1'b0;
        end
        if (m_ok) begin
            m_pending = d;
            m_pvalid  = 1'b1;
        end
        m_low     = e ? 0 : m_low + 1;
        m_prev_en = e;
        m_t++;
    endtask

    task automatic tick(input logic e, input logic [7:0] d);
        en         = e;
        shift_data = d;
        @(posedge clk);
        model_step(e, d);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) tick(1'b0, d);
        tick(1'b1, d);
    endtask

    task automatic apply_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        en         = 1'b1;
        shift_data = 8'h00;
        #2;
        checks++;
        if ({duty, led_out, frame_ok, frame_err} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000", {duty, led_out, frame_ok, frame_err});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_valid_frame();
        int highs;
        send_frame(8, 8'h40);
        checks++;
        if ({frame_ok, frame_err} !== 2'b10) begin
            errors++;
            $display("FAIL valid_pulse: got ok/err %b expected 10", {frame_ok, frame_err});
        end
        tick(1'b1, 8'h00);
        checks++;
        if (frame_ok !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got ok %b expected 0", frame_ok);
        end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 8'h00);
            checks++;
            if ({duty, led_out, frame_ok, frame_err} !== {m_duty, m_led, m_ok, m_err}) begin
                errors++;
                $display("FAIL valid_track t=%0d: got %h expected %h", m_t,
                         {duty, led_out, frame_ok, frame_err}, {m_duty, m_led, m_ok, m_err});
            end
        end
        checks++;
        if (duty !== 8'h40) begin
            errors++;
            $display("FAIL valid_duty: got %h expected 40", duty);
        end
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 8'h00);
            if (led_out === 1'b1) highs++;
        end
        checks++;
        if (highs != 64) begin
            errors++;
            $display("FAIL valid_high_time: got %0d expected 64", highs);
        end
    endtask

    task automatic test_short_frame();
        send_frame(5, 8'h99);
        checks++;
        if ({frame_ok, frame_err, duty} !== {2'b01, 8'h40}) begin
            errors++;
            $display("FAIL short_frame: got ok/err/duty %h expected 140", {frame_ok, frame_err, duty});
        end
        tick(1'b1, 8'h00);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_one_cycle: got err %b expected 0", frame_err);
        end
    endtask

    task automatic test_long_frame();
        int lows;
        send_frame(12, 8'h55);
        checks++;
        if ({frame_ok, frame_err} !== 2'b01) begin
            errors++;
            $display("FAIL long_frame: got ok/err %b expected 01", {frame_ok, frame_err});
        end
        send_frame(8, 8'hFF);
        checks++;
        if (frame_ok !== 1'b1) begin
            errors++;
            $display("FAIL ff_frame_ok: got %b expected 1", frame_ok);
        end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 8'h00);
            checks++;
            if ({duty, led_out, frame_ok, frame_err} !== {m_duty, m_led, m_ok, m_err}) begin
                errors++;
                $display("FAIL ff_track t=%0d: got %h expected %h", m_t,
                         {duty, led_out, frame_ok, frame_err}, {m_duty, m_led, m_ok, m_err});
            end
        end
        checks++;
        if (duty !== 8'hFF) begin
            errors++;
            $display("FAIL ff_duty: got %h expected ff", duty);
        end
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1'b1, 8'h00);
            if (led_out === 1'b0) lows++;
        end
        checks++;
        if (lows != 1) begin
            errors++;
            $display("FAIL ff_low_time: got %0d expected 1", lows);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_frame(8, 8'h10);
        tick(1'b1, 8'h00);
        send_frame(8, 8'h80);
        checks++;
        if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_ok: got ok/err %b expected 10", {frame_ok, frame_err});
        end
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 8'h00);
            checks++;
            if (duty === 8'h10 || duty !== m_duty) begin
                errors++;
                $display("FAIL b2b_duty t=%0d: got %h expected %h", m_t, duty, m_duty);
            end
        end
        checks++;
        if (duty !== 8'h80) begin
            errors++;
            $display("FAIL b2b_final: got %h expected 80", duty);
        end
    endtask

    task automatic test_coincide();
        apply_reset();
        send_frame(8, 8'h20);
        for (int i = 0; i < 256 && (m_t % 256) != 247; i++) tick(1'b1, 8'h00);
        send_frame(8, 8'h30);
        checks++;
        if ({duty, frame_ok} !== {8'h20, 1'b1}) begin
            errors++;
            $display("FAIL coincide_now: got duty/ok %h expected 41", {duty, frame_ok});
        end
        for (int i = 0; i < 257; i++) begin
            tick(1'b1, 8'h00);
            checks++;
            if ({duty, led_out, frame_ok, frame_err} !== {m_duty, m_led, m_ok, m_err}) begin
                errors++;
                $display("FAIL coincide_track t=%0d: got %h expected %h", m_t,
                         {duty, led_out, frame_ok, frame_err}, {m_duty, m_led, m_ok, m_err});
            end
        end
        checks++;
        if (duty !== 8'h30) begin
            errors++;
            $display("FAIL coincide_next: got %h expected 30", duty);
        end
    endtask

    task automatic test_random();
        int gap;
        int n;
        for (int f = 0; f < 150; f++) begin
            gap = int'($urandom_range(1, 20));
            n   = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(5, 11));
            for (int k = 0; k < gap + n; k++) begin
                tick((k < gap) ? 1'b1 : 1'b0, 8'($urandom));
                checks++;
                if ({duty, led_out, frame_ok, frame_err} !== {m_duty, m_led, m_ok, m_err} ||
                    (frame_ok === 1'b1 && frame_err === 1'b1)) begin
                    errors++;
                    $display("FAIL random t=%0d: got %h expected %h", m_t,
                             {duty, led_out, frame_ok, frame_err}, {m_duty, m_led, m_ok, m_err});
                end
            end
        end
        tick(1'b1, 8'h00);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 4; i++) tick(1'b0, 8'hA5);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({duty, led_out, frame_ok, frame_err} !== 11'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 000", {duty, led_out, frame_ok, frame_err});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 8'hA5);
        tick(1'b1, 8'hA5);
        checks++;
        if ({frame_ok, frame_err, duty} !== {2'b01, 8'h00}) begin
            errors++;
            $display("FAIL midreset_err: got ok/err/duty %h expected 100", {frame_ok, frame_err, duty});
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'h00);
            checks++;
            if ({duty, led_out, frame_ok, frame_err} !== {m_duty, m_led, m_ok, m_err}) begin
                errors++;
                $display("FAIL midreset_track t=%0d: got %h expected %h", m_t,
                         {duty, led_out, frame_ok, frame_err}, {m_duty, m_led, m_ok, m_err});
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_valid_frame();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_coincide();
        test_random();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
